// File: rtl/m2v_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester indices, burst sizing.
package m2v_pkg;

    localparam int BURST_W = 5;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t RCMD   = 2'd1;
    localparam state_t RBURST = 2'd2;
    localparam state_t WBURST = 2'd3;

    localparam logic [1:0] WB = 2'd0;
    localparam logic [1:0] MC = 2'd1;
    localparam logic [1:0] DP = 2'd2;

    // A 4-bit burstcount of zero encodes a full 16-beat burst.
    function automatic logic [BURST_W-1:0] burst_len(input logic [3:0] bc);
        return (bc == 4'd0) ? 5'd16 : {1'b0, bc};
    endfunction

endpackage

// File: rtl/m2vmemarb_rr.sv
// 3-way round-robin picker (wb->mc->dp) with display-urgent override.
// Latency: pick is combinational; pointer updates on the clock after a non-urgent take.
// Backpressure: none; caller asserts take only when the pick is actually granted.
module m2vmemarb_rr
    import m2v_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       urgent,
    input  logic       take,
    output logic [1:0] pick,
    output logic       pick_vld
);

    logic [1:0] last;

    always_comb begin
        pick     = WB;
        pick_vld = |req;
        if (urgent) begin
            pick = DP;
        end else begin
            case (last)
                WB:      pick = req[MC] ? MC : (req[DP] ? DP : WB);
                MC:      pick = req[DP] ? DP : (req[WB] ? WB : MC);
                default: pick = req[WB] ? WB : (req[MC] ? MC : DP);
            endcase
        end
    end

    // Urgent grants bypass fairness and leave the rotation untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= DP;
        end else if (take && !urgent) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/m2vmemarb.sv
// Arbitrates writeback, MC reference reads and display reads onto one Avalon-MM burst master.
// Latency: grant in the IDLE cycle req is seen, memory command on the next cycle; one burst at a time.
// Backpressure: avm_waitrequest stalls command/write beats; no preemption of an in-flight burst.
module m2vmemarb
    import m2v_pkg::*;
#(
    parameter int MEM_WIDTH  = 21,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  wb_req,
    input  logic [MEM_WIDTH-1:0]  wb_address,
    input  logic [3:0]            wb_burstcount,
    input  logic [DATA_WIDTH-1:0] wb_writedata,
    output logic                  wb_ready,
    output logic                  wb_grant,

    input  logic                  mc_req,
    input  logic [MEM_WIDTH-1:0]  mc_address,
    input  logic [3:0]            mc_burstcount,
    output logic                  mc_grant,
    output logic                  mc_rdvalid,

    input  logic                  dp_req,
    input  logic                  dp_urgent,
    input  logic [MEM_WIDTH-1:0]  dp_address,
    input  logic [3:0]            dp_burstcount,
    output logic                  dp_grant,
    output logic                  dp_rdvalid,

    output logic [DATA_WIDTH-1:0] rd_data,

    output logic [MEM_WIDTH-1:0]  avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [BURST_W-1:0]    avm_burstcount,
    output logic [DATA_WIDTH-1:0] avm_writedata,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid,
    input  logic [DATA_WIDTH-1:0] avm_readdata
);

    state_t                 state;
    logic [1:0]             owner;
    logic [MEM_WIDTH-1:0]   addr_q;
    logic [BURST_W-1:0]     burst_q;
    logic [BURST_W-1:0]     beats_q;

    logic [1:0]             pick;
    logic                   pick_vld;
    logic                   take;
    logic [MEM_WIDTH-1:0]   sel_addr;
    logic [3:0]             sel_bc;

    assign take = (state == IDLE) && pick_vld && !reset;

    m2vmemarb_rr u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      ({dp_req, mc_req, wb_req}),
        .urgent   (dp_req && dp_urgent),
        .take     (take),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    always_comb begin
        sel_addr = wb_address;
        sel_bc   = wb_burstcount;
        case (pick)
            MC: begin
                sel_addr = mc_address;
                sel_bc   = mc_burstcount;
            end
            DP: begin
                sel_addr = dp_address;
                sel_bc   = dp_burstcount;
            end
            default: begin
                sel_addr = wb_address;
                sel_bc   = wb_burstcount;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= WB;
            addr_q  <= '0;
            burst_q <= '0;
            beats_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        owner   <= pick;
                        addr_q  <= sel_addr;
                        burst_q <= burst_len(sel_bc);
                        beats_q <= burst_len(sel_bc);
                        state   <= (pick == WB) ? WBURST : RCMD;
                    end
                end
                RCMD: begin
                    if (!avm_waitrequest) begin
                        state <= RBURST;
                    end
                end
                RBURST: begin
                    if (avm_readdatavalid) begin
                        beats_q <= beats_q - 5'd1;
                        if (beats_q == 5'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                WBURST: begin
                    if (!avm_waitrequest) begin
                        beats_q <= beats_q - 5'd1;
                        if (beats_q == 5'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_grant = take && (pick == WB);
    assign mc_grant = take && (pick == MC);
    assign dp_grant = take && (pick == DP);

    assign avm_read       = (state == RCMD);
    assign avm_write      = (state == WBURST);
    assign avm_address    = addr_q;
    assign avm_burstcount = burst_q;
    assign avm_writedata  = wb_writedata;
    assign wb_ready       = (state == WBURST) && !avm_waitrequest;

    // Read beats pass straight through to whichever port owns the burst.
    assign rd_data    = avm_readdata;
    assign mc_rdvalid = (state == RBURST) && avm_readdatavalid && (owner == MC);
    assign dp_rdvalid = (state == RBURST) && avm_readdatavalid && (owner == DP);

endmodule

// File: tb/tb_m2vmemarb.sv
// Directed bench for m2vmemarb: arbitration order, urgent override, bursts, waitrequest, reset.
module tb_m2vmemarb;

    localparam int MW = 21;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_req, mc_req, dp_req, dp_urgent;
    logic [MW-1:0] wb_address, mc_address, dp_address;
    logic [3:0]    wb_burstcount, mc_burstcount, dp_burstcount;
    logic [DW-1:0] wb_writedata;
    logic          wb_ready, wb_grant, mc_grant, dp_grant, mc_rdvalid, dp_rdvalid;
    logic [DW-1:0] rd_data;
    logic [MW-1:0] avm_address;
    logic          avm_read, avm_write;
    logic [4:0]    avm_burstcount;
    logic [DW-1:0] avm_writedata;
    logic          avm_waitrequest, avm_readdatavalid;
    logic [DW-1:0] avm_readdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m2vmemarb #(.MEM_WIDTH(MW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .wb_req(wb_req), .wb_address(wb_address), .wb_burstcount(wb_burstcount),
        .wb_writedata(wb_writedata), .wb_ready(wb_ready), .wb_grant(wb_grant),
        .mc_req(mc_req), .mc_address(mc_address), .mc_burstcount(mc_burstcount),
        .mc_grant(mc_grant), .mc_rdvalid(mc_rdvalid),
        .dp_req(dp_req), .dp_urgent(dp_urgent), .dp_address(dp_address),
        .dp_burstcount(dp_burstcount), .dp_grant(dp_grant), .dp_rdvalid(dp_rdvalid),
        .rd_data(rd_data),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata)
    );

    wire [2:0] grants = {wb_grant, mc_grant, dp_grant};
    wire [7:0] all_ctl = {avm_read, avm_write, wb_ready, mc_rdvalid, dp_rdvalid,
                          wb_grant, mc_grant, dp_grant};

    // Inputs change at edge+1, outputs are sampled at edge+2.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wb_req = 0; mc_req = 0; dp_req = 0; dp_urgent = 0;
        wb_address = '0; mc_address = '0; dp_address = '0;
        wb_burstcount = '0; mc_burstcount = '0; dp_burstcount = '0;
        wb_writedata = '0; avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
        tick; tick;
        n_checks++;
        if (all_ctl !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", all_ctl, 8'h00);
        end
        reset = 1'b0;
        tick;
        n_checks++;
        if (all_ctl !== 8'h00) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected %b", all_ctl, 8'h00);
        end
    endtask

    task automatic test_rr;
        tick;
        wb_req = 1; wb_address = 21'h000100; wb_burstcount = 4'd1; wb_writedata = 32'hA5A50001;
        mc_req = 1; mc_address = 21'h000200; mc_burstcount = 4'd1;
        dp_req = 1; dp_address = 21'h000300; dp_burstcount = 4'd1;
        #1;
        n_checks++;
        if (grants !== 3'b100) begin n_fail++; $display("FAIL rr_first_wb: got %b expected %b", grants, 3'b100); end
        tick; wb_req = 0; #1;
        n_checks++;
        if ({avm_write, wb_ready, avm_address, avm_burstcount, avm_writedata} !==
            {1'b1, 1'b1, 21'h000100, 5'd1, 32'hA5A50001}) begin
            n_fail++; $display("FAIL rr_wb_write: got w=%b rdy=%b a=%h bc=%0d d=%h expected 1 1 000100 1 a5a50001",
                               avm_write, wb_ready, avm_address, avm_burstcount, avm_writedata);
        end
        tick; #1;
        n_checks++;
        if (grants !== 3'b010) begin n_fail++; $display("FAIL rr_second_mc: got %b expected %b", grants, 3'b010); end
        tick; mc_req = 0; #1;
        n_checks++;
        if ({avm_read, avm_write, avm_address} !== {1'b1, 1'b0, 21'h000200}) begin
            n_fail++; $display("FAIL rr_mc_cmd: got r=%b w=%b a=%h expected 1 0 000200", avm_read, avm_write, avm_address);
        end
        tick; avm_readdatavalid = 1; avm_readdata = 32'h11112222; #1;
        n_checks++;
        if ({mc_rdvalid, dp_rdvalid, rd_data} !== {1'b1, 1'b0, 32'h11112222}) begin
            n_fail++; $display("FAIL rr_mc_beat: got mv=%b dv=%b d=%h expected 1 0 11112222", mc_rdvalid, dp_rdvalid, rd_data);
        end
        tick; avm_readdatavalid = 0; #1;
        n_checks++;
        if (grants !== 3'b001) begin n_fail++; $display("FAIL rr_third_dp: got %b expected %b", grants, 3'b001); end
        tick; dp_req = 0; #1;
        n_checks++;
        if ({avm_read, avm_address} !== {1'b1, 21'h000300}) begin
            n_fail++; $display("FAIL rr_dp_cmd: got r=%b a=%h expected 1 000300", avm_read, avm_address);
        end
        tick; avm_readdatavalid = 1; avm_readdata = 32'h33334444; #1;
        n_checks++;
        if ({mc_rdvalid, dp_rdvalid} !== 2'b01) begin
            n_fail++; $display("FAIL rr_dp_beat: got %b expected %b", {mc_rdvalid, dp_rdvalid}, 2'b01);
        end
        tick; avm_readdatavalid = 0; #1;
        n_checks++;
        if (all_ctl !== 8'h00) begin n_fail++; $display("FAIL rr_back_idle: got %b expected %b", all_ctl, 8'h00); end
    endtask

    task automatic test_burst16;
        int mc_cnt = 0;
        int dp_cnt = 0;
        tick;
        mc_req = 1; mc_address = 21'h1FFFF0; mc_burstcount = 4'd0; #1;
        n_checks++;
        if (grants !== 3'b010) begin n_fail++; $display("FAIL b16_grant: got %b expected %b", grants, 3'b010); end
        tick; mc_req = 0; #1;
        n_checks++;
        if ({avm_read, avm_burstcount, avm_address} !== {1'b1, 5'd16, 21'h1FFFF0}) begin
            n_fail++; $display("FAIL b16_cmd: got r=%b bc=%0d a=%h expected 1 16 1ffff0", avm_read, avm_burstcount, avm_address);
        end
        tick;
        for (int i = 0; i < 20; i++) begin
            avm_readdatavalid = ((i < 17) && (i != 3)) || (i == 18);
            avm_readdata = 32'hC0000000 + i;
            #1;
            if (mc_rdvalid) mc_cnt++;
            if (dp_rdvalid) dp_cnt++;
            if (i == 5) begin
                n_checks++;
                if ({mc_rdvalid, rd_data} !== {1'b1, 32'hC0000005}) begin
                    n_fail++; $display("FAIL b16_beat5: got v=%b d=%h expected 1 c0000005", mc_rdvalid, rd_data);
                end
            end
            tick;
        end
        avm_readdatavalid = 0;
        n_checks++;
        if (mc_cnt != 16) begin n_fail++; $display("FAIL b16_mc_beats: got %0d expected 16", mc_cnt); end
        n_checks++;
        if (dp_cnt != 0) begin n_fail++; $display("FAIL b16_dp_beats: got %0d expected 0", dp_cnt); end
    endtask

    task automatic test_urgent;
        int wcyc = 0;
        int rdy = 0;
        int preempt = 0;
        int abad = 0;
        tick;
        wb_req = 1; wb_address = 21'h000400; wb_burstcount = 4'd8; #1;
        n_checks++;
        if (grants !== 3'b100) begin n_fail++; $display("FAIL urg_wb_grant: got %b expected %b", grants, 3'b100); end
        tick;
        wb_req = 0;
        mc_req = 1; mc_address = 21'h000500; mc_burstcount = 4'd2;
        dp_req = 1; dp_urgent = 1; dp_address = 21'h000600; dp_burstcount = 4'd1;
        for (int i = 0; i < 8; i++) begin
            wb_writedata = 32'hD0000000 + i;
            #1;
            if (avm_write) wcyc++;
            if (wb_ready) rdy++;
            if (grants != 3'b000) preempt++;
            if (avm_address !== 21'h000400) abad++;
            tick;
        end
        n_checks++;
        if ({wcyc, rdy, preempt, abad} != {32'd8, 32'd8, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL urg_write8: got w=%0d r=%0d pre=%0d abad=%0d expected 8 8 0 0", wcyc, rdy, preempt, abad);
        end
        #1;
        n_checks++;
        if (grants !== 3'b001) begin n_fail++; $display("FAIL urg_dp_first: got %b expected %b", grants, 3'b001); end
        tick; dp_req = 0; dp_urgent = 0; #1;
        n_checks++;
        if ({avm_read, avm_address} !== {1'b1, 21'h000600}) begin
            n_fail++; $display("FAIL urg_dp_cmd: got r=%b a=%h expected 1 000600", avm_read, avm_address);
        end
        tick; avm_readdatavalid = 1; avm_readdata = 32'h0000BEEF; #1;
        n_checks++;
        if ({mc_rdvalid, dp_rdvalid, rd_data} !== {1'b0, 1'b1, 32'h0000BEEF}) begin
            n_fail++; $display("FAIL urg_dp_beat: got mv=%b dv=%b d=%h expected 0 1 0000beef", mc_rdvalid, dp_rdvalid, rd_data);
        end
        tick; avm_readdatavalid = 0; #1;
        n_checks++;
        if (grants !== 3'b010) begin n_fail++; $display("FAIL urg_then_mc: got %b expected %b", grants, 3'b010); end
        tick; mc_req = 0;
        tick; avm_readdatavalid = 1;
        tick; tick; avm_readdatavalid = 0;
    endtask

    task automatic test_waitreq;
        int rcyc = 0;
        int abad = 0;
        int rdy = 0;
        int wcyc = 0;
        int badrdy = 0;
        logic [9:0] wait_pat;
        wait_pat = 10'b0001001101;
        tick;
        mc_req = 1; mc_address = 21'h00ABCD; mc_burstcount = 4'd4; #1;
        n_checks++;
        if (grants !== 3'b010) begin n_fail++; $display("FAIL wr_mc_grant: got %b expected %b", grants, 3'b010); end
        tick; mc_req = 0;
        for (int i = 0; i < 4; i++) begin
            avm_waitrequest = (i < 3);
            #1;
            if (avm_read) rcyc++;
            if (avm_address !== 21'h00ABCD) abad++;
            tick;
        end
        avm_waitrequest = 0; #1;
        n_checks++;
        if ({rcyc, abad} != {32'd4, 32'd0} || avm_read !== 1'b0) begin
            n_fail++; $display("FAIL wr_read_hold: got cyc=%0d abad=%0d r_after=%b expected 4 0 0", rcyc, abad, avm_read);
        end
        avm_readdatavalid = 1;
        repeat (4) tick;
        avm_readdatavalid = 0;
        tick;
        wb_req = 1; wb_address = 21'h000007; wb_burstcount = 4'd4; #1;
        n_checks++;
        if (grants !== 3'b100) begin n_fail++; $display("FAIL wr_wb_grant: got %b expected %b", grants, 3'b100); end
        tick; wb_req = 0;
        for (int i = 0; i < 10; i++) begin
            avm_waitrequest = wait_pat[i];
            #1;
            if (wb_ready) rdy++;
            if (avm_write) wcyc++;
            if (wb_ready && avm_waitrequest) badrdy++;
            tick;
        end
        avm_waitrequest = 0;
        n_checks++;
        if ({rdy, wcyc, badrdy} != {32'd4, 32'd8, 32'd0}) begin
            n_fail++; $display("FAIL wr_write_toggle: got rdy=%0d wcyc=%0d bad=%0d expected 4 8 0", rdy, wcyc, badrdy);
        end
    endtask

    task automatic test_reset_mid;
        tick;
        mc_req = 1; mc_address = 21'h000020; mc_burstcount = 4'd8; #1;
        n_checks++;
        if (grants !== 3'b010) begin n_fail++; $display("FAIL rm_grant: got %b expected %b", grants, 3'b010); end
        tick; mc_req = 0;
        tick; avm_readdatavalid = 1;
        repeat (5) tick;
        reset = 1;
        tick;
        reset = 0; #1;
        n_checks++;
        if (all_ctl !== 8'h00) begin n_fail++; $display("FAIL rm_outputs_zero: got %b expected %b", all_ctl, 8'h00); end
        tick; avm_readdatavalid = 0;
        mc_req = 1; mc_address = 21'h000040; mc_burstcount = 4'd1;
        dp_req = 1; dp_address = 21'h000050; dp_burstcount = 4'd1; #1;
        n_checks++;
        if (grants !== 3'b010) begin n_fail++; $display("FAIL rm_ptr_reset: got %b expected %b", grants, 3'b010); end
        mc_req = 0; dp_req = 0; reset = 1;
        tick; reset = 0;
    endtask

    task automatic test_stray;
        int stray = 0;
        tick;
        avm_readdatavalid = 1; avm_readdata = 32'hDEADDEAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mc_rdvalid || dp_rdvalid || avm_read || avm_write) stray++;
            tick;
        end
        n_checks++;
        if (stray != 0) begin n_fail++; $display("FAIL stray_rdvalid: got %0d expected 0", stray); end
        avm_readdatavalid = 0;
        wb_req = 1; wb_address = 21'h000055; wb_burstcount = 4'd2; #1;
        n_checks++;
        if (grants !== 3'b100) begin n_fail++; $display("FAIL stray_then_grant: got %b expected %b", grants, 3'b100); end
        tick; wb_req = 0; #1;
        n_checks++;
        if ({avm_write, avm_burstcount} !== {1'b1, 5'd2}) begin
            n_fail++; $display("FAIL stray_write_cmd: got w=%b bc=%0d expected 1 2", avm_write, avm_burstcount);
        end
        tick; tick; #1;
        n_checks++;
        if (avm_write !== 1'b0) begin n_fail++; $display("FAIL stray_write_done: got %b expected 0", avm_write); end
    endtask

    initial begin
        test_reset;
        test_rr;
        test_burst16;
        test_urgent;
        test_waitreq;
        test_reset_mid;
        test_stray;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
